// File: rtl/bram_stream_reader.sv
// Sequential BRAM read engine presenting words as a valid/ready stream with a 2-entry skid buffer.
// Optional macro BRAM_READER_LAST_EN adds last_o, flagging the final word of a transfer.
module bram_stream_reader #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [RAM_ADDR_BITS-1:0] base_addr_i,
    input  logic [RAM_ADDR_BITS:0]   len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [RAM_ADDR_BITS-1:0] ram_addr_o,
    output logic                     ram_en_o,
    output logic                     ram_we_o,
    input  logic [RAM_WIDTH-1:0]     ram_data_i,
    output logic [RAM_WIDTH-1:0]     m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i
`ifdef BRAM_READER_LAST_EN
    ,
    output logic                     last_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_nextState;

    logic [RAM_ADDR_BITS-1:0] r_base;
    logic [RAM_ADDR_BITS-1:0] r_addrHold;
    logic [RAM_ADDR_BITS:0]   r_len;
    logic [RAM_ADDR_BITS:0]   r_issued;
    logic [RAM_ADDR_BITS:0]   r_delivered;
    logic                     r_inflight;

    logic [RAM_WIDTH-1:0]     r_buf [2];
    logic                     r_rdPtr;
    logic                     r_wrPtr;
    logic [1:0]               r_occ;

    logic                     w_issue;
    logic                     w_push;
    logic                     w_pop;
    logic [2:0]               w_level;
    logic [RAM_ADDR_BITS-1:0] w_issueAddr;

    assign w_pop       = (r_occ != 2'd0) && m_ready_i;
    assign w_push      = r_inflight;
    assign w_level     = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issueAddr = r_base + r_issued[RAM_ADDR_BITS-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A read is only issued when the word it returns is certain to find a free buffer slot.
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_nextState = (len_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_issue = (r_issued < r_len) && (w_level < 3'd2);
                if (w_pop && ((r_delivered + 1'b1) == r_len)) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_base      <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_addrHold  <= '0;
            r_inflight  <= 1'b0;
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
            r_rdPtr     <= 1'b0;
            r_wrPtr     <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            if ((r_state == S_IDLE) && start_i && (len_i != '0)) begin
                r_base      <= base_addr_i;
                r_len       <= len_i;
                r_issued    <= '0;
                r_delivered <= '0;
            end
            if (w_issue) begin
                r_issued   <= r_issued + 1'b1;
                r_addrHold <= w_issueAddr;
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_buf[r_wrPtr] <= ram_data_i;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr     <= ~r_rdPtr;
                r_delivered <= r_delivered + 1'b1;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef BRAM_READER_LAST_EN
    logic r_inflightLast;
    logic r_lastBuf [2];

    // The last flag travels with its word: tagged at issue, stored on capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflightLast <= 1'b0;
            r_lastBuf[0]   <= 1'b0;
            r_lastBuf[1]   <= 1'b0;
        end else begin
            r_inflightLast <= w_issue && (r_issued == (r_len - 1'b1));
            if (w_push) begin
                r_lastBuf[r_wrPtr] <= r_inflightLast;
            end
        end
    end

    assign last_o = (r_occ != 2'd0) && r_lastBuf[r_rdPtr];
`endif

    assign ram_addr_o = w_issue ? w_issueAddr : r_addrHold;
    assign ram_en_o   = w_issue;
    assign ram_we_o   = 1'b0;
    assign m_data_o   = r_buf[r_rdPtr];
    assign m_valid_o  = (r_occ != 2'd0);
    assign busy_o     = (r_state == S_RUN);
    assign done_o     = (r_state == S_DONE);

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed self-checking bench for bram_stream_reader, with a behavioural 1-cycle BRAM preloaded mem[a]=a[7:0].
// Define BRAM_READER_LAST_EN to also check last_o.
module tb_bram_stream_reader;

    localparam int W  = 8;
    localparam int AB = 10;
    localparam int DEPTH = 1 << AB;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AB-1:0] base_addr_i = '0;
    logic [AB:0]   len_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [AB-1:0] ram_addr_o;
    logic          ram_en_o;
    logic          ram_we_o;
    logic [W-1:0]  ram_data_i = '0;
    logic [W-1:0]  m_data_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b1;
`ifdef BRAM_READER_LAST_EN
    logic          last_o;
`endif

    bram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ram_addr_o  (ram_addr_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_data_i  (ram_data_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i)
`ifdef BRAM_READER_LAST_EN
        ,
        .last_o      (last_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    logic [W-1:0] mem [DEPTH];

    always @(posedge clk_i) begin
        if (ram_en_o) ram_data_i <= mem[ram_addr_o];
    end

    int checks = 0;
    int failures = 0;

    int enAddrs[$];
    int enCycles[$];
    int words[$];
    int wordCycles[$];
    int lastFlags[$];
    int doneCount;
    int doneCycle;
    int busySeen;
    int weSeen;
    int stableViol;
    int maxOut;
    int resetHit;
    int restartBase;
    int restartLen;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int base, input int len);
        @(negedge clk_i);
        base_addr_i = AB'(base);
        len_i       = (AB+1)'(len);
        start_i     = 1'b1;
        m_ready_i   = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    // Cycle c=1 is the first cycle after the edge that accepted start.
    task automatic collect(input int budget, input int randomReady, input int restartCycle, input int resetAfter);
        logic [W-1:0] prevData;
        int prevHold;
        enAddrs.delete(); enCycles.delete(); words.delete(); wordCycles.delete(); lastFlags.delete();
        doneCount = 0; doneCycle = -1; busySeen = 0; weSeen = 0; stableViol = 0; maxOut = 0; resetHit = 0;
        prevHold = 0; prevData = '0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk_i);
            start_i = (c == restartCycle);
            if (c == restartCycle) begin
                base_addr_i = AB'(restartBase);
                len_i       = (AB+1)'(restartLen);
            end
            m_ready_i = (randomReady != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (resetAfter > 0 && words.size() == resetAfter) begin
                #2 rst_i = 1'b1;
                #1;
                checkOutput("rst_busy", 32'(busy_o), 0);
                checkOutput("rst_done", 32'(done_o), 0);
                checkOutput("rst_valid", 32'(m_valid_o), 0);
                checkOutput("rst_data", 32'(m_data_o), 0);
                checkOutput("rst_en", 32'(ram_en_o), 0);
                checkOutput("rst_addr", 32'(ram_addr_o), 0);
                resetHit = 1;
                break;
            end
            #1;
            if (enAddrs.size() - words.size() > maxOut) maxOut = enAddrs.size() - words.size();
            if (ram_we_o) weSeen++;
            if (ram_en_o) begin
                enAddrs.push_back(int'(ram_addr_o));
                enCycles.push_back(c);
            end
            if (prevHold != 0 && (!m_valid_o || m_data_o !== prevData)) stableViol++;
            if (m_valid_o && m_ready_i) begin
                words.push_back(int'(m_data_o));
                wordCycles.push_back(c);
`ifdef BRAM_READER_LAST_EN
                lastFlags.push_back(int'(last_o));
`else
                lastFlags.push_back(0);
`endif
            end
            prevHold = (m_valid_o && !m_ready_i) ? 1 : 0;
            prevData = m_data_o;
            if (busy_o) busySeen++;
            if (done_o) begin
                doneCount++;
                doneCycle = c;
                break;
            end
        end
        start_i   = 1'b0;
        m_ready_i = 1'b1;
    endtask

    task automatic checkSeq(input string tag, input int base, input int len);
        checkOutput({tag, "_en_count"}, 32'(enAddrs.size()), 32'(len));
        checkOutput({tag, "_word_count"}, 32'(words.size()), 32'(len));
        for (int i = 0; i < len && i < words.size() && i < enAddrs.size(); i++) begin
            checkOutput({tag, "_addr"}, 32'(enAddrs[i]), 32'((base + i) % DEPTH));
            checkOutput({tag, "_word"}, 32'(words[i]), 32'((base + i) & 8'hFF));
        end
        checkOutput({tag, "_we"}, 32'(weSeen), 0);
        checkOutput({tag, "_stable"}, 32'(stableViol), 0);
        checkOutput({tag, "_outstanding_le2"}, 32'(maxOut <= 2), 1);
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a);
        restartBase = 0;
        restartLen  = 0;

        // Reset state while reset is held and just after release
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_busy", 32'(busy_o), 0);
        checkOutput("reset_done", 32'(done_o), 0);
        checkOutput("reset_valid", 32'(m_valid_o), 0);
        checkOutput("reset_data", 32'(m_data_o), 0);
        checkOutput("reset_en", 32'(ram_en_o), 0);
        checkOutput("reset_addr", 32'(ram_addr_o), 0);
        checkOutput("reset_we", 32'(ram_we_o), 0);
`ifdef BRAM_READER_LAST_EN
        checkOutput("reset_last", 32'(last_o), 0);
`endif
        rst_i = 1'b0;

        // Basic transfer: base 0x010, len 4, ready always high
        applyStimulus(32'h010, 4);
        collect(40, 0, 0, 0);
        checkSeq("basic", 32'h010, 4);
        checkOutput("basic_en_first_cycle", 32'(enCycles.size() > 0 ? enCycles[0] : -1), 1);
        checkOutput("basic_en_last_cycle", 32'(enCycles.size() > 3 ? enCycles[3] : -1), 4);
        checkOutput("basic_word_first_cycle", 32'(wordCycles.size() > 0 ? wordCycles[0] : -1), 3);
        checkOutput("basic_word_last_cycle", 32'(wordCycles.size() > 3 ? wordCycles[3] : -1), 6);
        checkOutput("basic_done_count", 32'(doneCount), 1);
        checkOutput("basic_done_cycle", 32'(doneCycle), 7);
        checkOutput("basic_busy_cycles", 32'(busySeen), 6);
`ifdef BRAM_READER_LAST_EN
        checkOutput("basic_last_w2", 32'(lastFlags.size() > 2 ? lastFlags[2] : -1), 0);
        checkOutput("basic_last_w3", 32'(lastFlags.size() > 3 ? lastFlags[3] : -1), 1);
`endif

        // Address wrap past the top of memory
        applyStimulus(32'h3FE, 4);
        collect(40, 0, 0, 0);
        checkSeq("wrap", 32'h3FE, 4);
        checkOutput("wrap_done_count", 32'(doneCount), 1);

        // Random backpressure
        applyStimulus(32'h100, 8);
        collect(300, 1, 0, 0);
        checkSeq("bp", 32'h100, 8);
        checkOutput("bp_done_count", 32'(doneCount), 1);

        // Zero-length transfer
        applyStimulus(0, 0);
        collect(20, 0, 0, 0);
        checkOutput("len0_en_count", 32'(enAddrs.size()), 0);
        checkOutput("len0_done_cycle", 32'(doneCycle), 1);
        checkOutput("len0_busy", 32'(busySeen), 0);

        // Reset after 3 of 10 words, then a clean transfer
        applyStimulus(32'h040, 10);
        collect(40, 0, 0, 3);
        checkOutput("midrst_hit", 32'(resetHit), 1);
        checkOutput("midrst_done_count", 32'(doneCount), 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput("postrst_idle", 32'({done_o, m_valid_o, busy_o, ram_en_o}), 0);
        end
        applyStimulus(0, 2);
        collect(40, 0, 0, 0);
        checkSeq("postrst", 0, 2);
        checkOutput("postrst_done_cycle", 32'(doneCycle), 5);

        // Second start mid-transfer is ignored
        restartBase = 32'h200;
        restartLen  = 3;
        applyStimulus(32'h020, 10);
        collect(60, 0, 4, 0);
        checkSeq("restart", 32'h020, 10);
        checkOutput("restart_done_count", 32'(doneCount), 1);
        checkOutput("restart_done_cycle", 32'(doneCycle), 13);
`ifdef BRAM_READER_LAST_EN
        for (int i = 0; i < 10 && i < lastFlags.size(); i++) begin
            checkOutput("restart_last", 32'(lastFlags[i]), 32'(i == 9));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
